// File: rtl/alu_acc_pkg.sv
// Shared opcodes, FSM state type and default width for the accumulator controller.
package alu_acc_pkg;

    localparam int ALU_ACC_W = 4;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_acc_mul.sv
// Shift-add multiply iteration datapath: W steps over a 2W-bit partial product.
// Only built when ALU_ACC_MUL_EN is defined.
module alu_acc_mul
    import alu_acc_pkg::*;
#(
    parameter int W = ALU_ACC_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    output logic           done,
    output logic [2*W-1:0] prod_next
);

    localparam int CW = $clog2(W + 1);

    logic           running_q, running_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [2*W-1:0] p_q, p_d;
    logic [W:0]     upper_sum;

    // Upper half keeps its carry so the right shift never loses the top bit.
    assign upper_sum = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_next = {upper_sum, p_q[W-1:1]};
    assign done      = running_q && (cnt_q == CW'(W - 1));

    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        p_d       = p_q;
        if (start) begin
            running_d = 1'b1;
            cnt_d     = '0;
            mcand_d   = mcand;
            p_d       = {{W{1'b0}}, mplier};
        end else if (running_q) begin
            p_d   = prod_next;
            cnt_d = cnt_q + CW'(1);
            if (done) begin
                running_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mcand_q <= mcand_d;
        p_q     <= p_d;
    end

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator controller: one command per handshake, registered response channel.
// ALU_ACC_MUL_EN enables the multi-cycle shift-add MUL for opcode 7.
module alu_acc_ctrl
    import alu_acc_pkg::*;
#(
    parameter int W = ALU_ACC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_operand,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_carry,
    output logic         rsp_lt,
    output logic         rsp_eq,
    output logic         rsp_gt,
    output logic         rsp_err,
    output logic [W-1:0] acc
);

    state_e       state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic         cmd_ready_q, cmd_ready_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [W-1:0] rsp_result_q, rsp_result_d;
    logic         rsp_carry_q, rsp_carry_d;
    logic         rsp_lt_q, rsp_lt_d;
    logic         rsp_eq_q, rsp_eq_d;
    logic         rsp_gt_q, rsp_gt_d;
    logic         rsp_err_q, rsp_err_d;

    logic [W:0]   add_sum, sub_sum;
    logic [W-1:0] alu_res;
    logic         alu_carry;
    logic         alu_err;

`ifdef ALU_ACC_MUL_EN
    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_prod;

    assign mul_start = (state_q == IDLE) && cmd_valid && (cmd_op == OP_MUL);

    alu_acc_mul #(.W(W)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start),
        .mcand     (acc_q),
        .mplier    (cmd_operand),
        .done      (mul_done),
        .prod_next (mul_prod)
    );
`endif

    // SUB carry-out is the no-borrow indication.
    assign add_sum = {1'b0, acc_q} + {1'b0, cmd_operand};
    assign sub_sum = {1'b0, acc_q} + {1'b0, ~cmd_operand} + {{W{1'b0}}, 1'b1};

    always_comb begin
        alu_res   = acc_q;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (cmd_op)
            OP_LOAD: alu_res = cmd_operand;
            OP_ADD:  {alu_carry, alu_res} = add_sum;
            OP_SUB:  {alu_carry, alu_res} = sub_sum;
            OP_AND:  alu_res = acc_q & cmd_operand;
            OP_OR:   alu_res = acc_q | cmd_operand;
            OP_XOR:  alu_res = acc_q ^ cmd_operand;
            OP_NOT:  alu_res = ~acc_q;
            OP_MUL: begin
                alu_res = acc_q;
`ifndef ALU_ACC_MUL_EN
                alu_err = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_lt_d     = rsp_lt_q;
        rsp_eq_d     = rsp_eq_q;
        rsp_gt_d     = rsp_gt_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rsp_lt_d  = acc_q < cmd_operand;
                    rsp_eq_d  = acc_q == cmd_operand;
                    rsp_gt_d  = acc_q > cmd_operand;
                    rsp_err_d = alu_err;
`ifdef ALU_ACC_MUL_EN
                    if (cmd_op == OP_MUL) begin
                        state_d = MUL;
                    end else
`endif
                    begin
                        state_d      = RESP;
                        acc_d        = alu_res;
                        rsp_result_d = alu_res;
                        rsp_carry_d  = alu_carry;
                        rsp_valid_d  = 1'b1;
                    end
                end
            end
`ifdef ALU_ACC_MUL_EN
            MUL: begin
                if (mul_done) begin
                    state_d      = RESP;
                    acc_d        = mul_prod[W-1:0];
                    rsp_result_d = mul_prod[W-1:0];
                    rsp_carry_d  = |mul_prod[2*W-1:W];
                    rsp_valid_d  = 1'b1;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_lt_q     <= 1'b0;
            rsp_eq_q     <= 1'b0;
            rsp_gt_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_lt_q     <= rsp_lt_d;
            rsp_eq_q     <= rsp_eq_d;
            rsp_gt_q     <= rsp_gt_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_lt     = rsp_lt_q;
    assign rsp_eq     = rsp_eq_q;
    assign rsp_gt     = rsp_gt_q;
    assign rsp_err    = rsp_err_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Self-checking bench for alu_acc_ctrl against an arithmetic reference model.
module tb_alu_acc_ctrl;

    localparam int W = 4;
`ifdef ALU_ACC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [W-1:0] cmd_operand = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic         rsp_carry, rsp_lt, rsp_eq, rsp_gt, rsp_err;
    logic [W-1:0] acc;

    int checks = 0;
    int failures = 0;
    int mdl_acc = 0;

    typedef struct packed {
        logic [3:0] res;
        logic       c;
        logic       lt;
        logic       eq;
        logic       gt;
        logic       err;
        logic [3:0] acc;
    } exp_t;

    alu_acc_ctrl #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_carry   (rsp_carry),
        .rsp_lt      (rsp_lt),
        .rsp_eq      (rsp_eq),
        .rsp_gt      (rsp_gt),
        .rsp_err     (rsp_err),
        .acc         (acc)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int r;
        int c;
        r = a;
        c = 0;
        e.err = 1'b0;
        case (op)
            0: r = b;
            1: begin r = a + b; c = (r >= 16) ? 1 : 0; end
            2: begin r = a - b; c = (a >= b) ? 1 : 0; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = 15 - a;
            default: begin
                if (MUL_EN) begin
                    r = a * b;
                    c = (r >= 16) ? 1 : 0;
                end else begin
                    r = a;
                    e.err = 1'b1;
                end
            end
        endcase
        r = r & 15;
        e.res = r[3:0];
        e.c   = (c != 0);
        e.lt  = a < b;
        e.eq  = a == b;
        e.gt  = a > b;
        e.acc = r[3:0];
        return e;
    endfunction

    function automatic int exp_latency(input int op);
        return (op == 7 && MUL_EN) ? W : 0;
    endfunction

    task automatic run_cmd(input string name, input int op, input int b, input int hold);
        exp_t e;
        int lat;
        logic [3:0] first_res;
        e = model(op, mdl_acc, b);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before: cmd_ready=%b required 1", name, cmd_ready);
        end
        cmd_valid   = 1'b1;
        cmd_op      = 3'(op);
        cmd_operand = 4'(b);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != exp_latency(op)) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_latency(op));
        end
        checks++;
        if ({rsp_result, rsp_carry} !== {e.res, e.c}) begin
            failures++;
            $display("FAIL %s result: got %0d carry %b required %0d carry %b",
                     name, rsp_result, rsp_carry, e.res, e.c);
        end
        checks++;
        if ({rsp_lt, rsp_eq, rsp_gt, rsp_err} !== {e.lt, e.eq, e.gt, e.err}) begin
            failures++;
            $display("FAIL %s flags: got lt/eq/gt/err=%b%b%b%b required %b%b%b%b",
                     name, rsp_lt, rsp_eq, rsp_gt, rsp_err, e.lt, e.eq, e.gt, e.err);
        end
        checks++;
        if ({acc, cmd_ready} !== {(e.err ? 4'(mdl_acc) : e.acc), 1'b0}) begin
            failures++;
            $display("FAIL %s acc: got acc=%0d ready=%b required acc=%0d ready=0",
                     name, acc, cmd_ready, e.err ? mdl_acc : int'(e.acc));
        end
        first_res = rsp_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_result} !== {1'b1, first_res}) begin
                failures++;
                $display("FAIL %s hold: valid=%b result=%0d required valid=1 result=%0d",
                         name, rsp_valid, rsp_result, first_res);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL %s release: valid=%b ready=%b required valid=0 ready=1",
                     name, rsp_valid, cmd_ready);
        end
        if (!e.err) mdl_acc = int'(e.acc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if ({acc, rsp_valid, cmd_ready, rsp_result, rsp_carry, rsp_lt, rsp_eq, rsp_gt, rsp_err}
            !== {4'd0, 1'b0, 1'b1, 4'd0, 5'b0}) begin
            failures++;
            $display("FAIL reset_values: acc=%0d valid=%b ready=%b result=%0d c/lt/eq/gt/err=%b%b%b%b%b",
                     acc, rsp_valid, cmd_ready, rsp_result, rsp_carry, rsp_lt, rsp_eq, rsp_gt, rsp_err);
        end
        mdl_acc = 0;
        run_cmd("rst_load9", 0, 9, 0);
        cmd_valid   = 1'b1;
        cmd_op      = 3'd7;
        cmd_operand = 4'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({acc, rsp_valid, cmd_ready} !== {4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_midstream: acc=%0d valid=%b ready=%b required 0 0 1",
                     acc, rsp_valid, cmd_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mdl_acc = 0;
    endtask

    task automatic test_arith();
        run_cmd("load9", 0, 9, 0);
        run_cmd("add8", 1, 8, 0);
        run_cmd("load3", 0, 3, 0);
        run_cmd("sub5", 2, 5, 1);
    endtask

    task automatic test_logic();
        run_cmd("load12", 0, 12, 0);
        run_cmd("and10", 3, 10, 0);
        run_cmd("or3", 4, 3, 0);
        run_cmd("xor11", 5, 11, 0);
        run_cmd("not", 6, 7, 0);
    endtask

    task automatic test_mul();
        run_cmd("mul_load6", 0, 6, 0);
        run_cmd("mul6x3", 7, 3, 0);
        run_cmd("mul_load3", 0, 3, 0);
        run_cmd("mul3x5", 7, 5, 2);
        run_cmd("mul_load5", 0, 5, 0);
        run_cmd("op7_acc5", 7, 2, 0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        run_cmd("bp_load5", 0, 5, 0);
        e = model(1, mdl_acc, 2);
        cmd_valid   = 1'b1;
        cmd_op      = 3'd0;
        cmd_operand = 4'd5;
        @(posedge clk); #1;
        cmd_op      = 3'd1;
        cmd_operand = 4'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_result, cmd_ready, acc} !== {1'b1, 4'd5, 1'b0, 4'd5}) begin
                failures++;
                $display("FAIL backpressure_hold: valid=%b result=%0d ready=%b acc=%0d required 1 5 0 5",
                         rsp_valid, rsp_result, cmd_ready, acc);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, acc} !== {1'b0, 1'b1, 4'd5}) begin
            failures++;
            $display("FAIL backpressure_release: valid=%b ready=%b acc=%0d required 0 1 5",
                     rsp_valid, cmd_ready, acc);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_result, rsp_carry, acc} !== {1'b1, e.res, e.c, e.acc}) begin
            failures++;
            $display("FAIL backpressure_next: valid=%b result=%0d carry=%b acc=%0d required 1 %0d %b %0d",
                     rsp_valid, rsp_result, rsp_carry, acc, e.res, e.c, e.acc);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        mdl_acc = int'(e.acc);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_cmd("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_arith();
        test_logic();
        test_mul();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
